multi_rate_counter_bank: RTL and testbench
==========================================

Name: multi_rate_counter_bank

Overview:
Parametrised successor to the two-channel select/enable counter pair. It provides NCH independent WIDTH-bit counters, each advancing at a runtime-programmable divided rate. Only the channel addressed by Slt advances while En is high. Each channel runs in wrap or saturate mode and emits a one-cycle terminal-count pulse. The block sits as a timing/event-count peripheral beside the datapath; legacy behaviour (ch0 every cycle, ch1 every 4 cycles) is the configuration NCH=2, Div0=1, Div1=4.

Parameters:
WIDTH, 64, bit width of each counter
NCH, 4, number of channels (2..16)
SEL_W, 2, width of Slt/Wr_ch; must satisfy 2^SEL_W >= NCH
DIV_W, 8, width of each divisor register
DEF_DIV, 1, reset value of every divisor register

Ports:
Clk  input  1  single clock, rising edge
Reset_n  input  1  asynchronous, active-low reset
En  input  1  count enable for the selected channel
Slt  input  SEL_W  selected channel index
Clr  input  1  synchronous clear of the selected channel
Sat  input  1  0 = wrap mode, 1 = saturate mode (global, runtime)
Wr_en  input  1  divisor write strobe
Wr_ch  input  SEL_W  divisor write channel index
Wr_div  input  DIV_W  divisor value to write
Count  output  NCH*WIDTH  flattened counters; channel i at [i*WIDTH +: WIDTH]
Tc  output  NCH  per-channel terminal-count pulse, registered

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - Count = 0, Tc = 0, all prescalers = 0, all Div = DEF_DIV.
  - Release is sampled at the next Clk edge.
- Per channel i, divisor D = Div_i. D = 0 disables the channel: no advance, prescaler held.
- Tick on channel i: En=1, Slt==i, D!=0 and pre_i == D-1.
  - On a tick, pre_i <= 0 and the counter advances.
  - With En=1, Slt==i, D!=0 and no tick, pre_i <= pre_i+1.
- Latency and rate:
  - D=1: Count_i increments on every enabled edge; the first increment occurs on the first edge with En=1.
  - D=N: the first increment occurs on the N-th enabled edge.
- Deselected or En=0: the channel's prescaler and count hold; phase is preserved across deselection.
- Slt >= NCH: no channel advances; Clr is ignored.
- Wrap mode (Sat=0):
  - On a tick with Count_i == 2^WIDTH-1, Count_i <= 0 and Tc_i = 1 for the next cycle.
- Saturate mode (Sat=1):
  - A tick at 2^WIDTH-2 sets Count_i to max and pulses Tc_i once.
  - Ticks at max hold the value with no further Tc.
- Clr (synchronous, regardless of En): Count_slt <= 0, pre_slt <= 0, no Tc. Clr has priority over a tick.
- Divisor write (Wr_en=1, Wr_ch < NCH):
  - Div_wrch <= Wr_div and pre_wrch <= 0.
  - If it coincides with a would-be tick on the same channel, the write wins and there is no increment that cycle.
  - If it coincides with Clr on the same channel, both take effect.
  - Wr_ch >= NCH: write ignored.
- Tc is a single-cycle registered pulse, asserted the cycle after the edge that wrapped or saturated the count.
- Reset asserted mid-count: everything returns to reset values immediately, independent of Clk.

Decomposition:
- Shared include/package (mrc_defs):
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Default localparams WIDTH/NCH/DIV_W.
  - Helper function for the channel-slice offset.
- One sub-module, mrc_channel, holds per-channel state: Div register, prescaler, counter, Tc flop.
  - Inputs: sel, En, Clr, Sat, wr, wr_div.
  - Top level: decodes Slt/Wr_ch into one-hot and instantiates NCH channels with a generate loop.

Test Plan:
1. Legacy mode:
   - Stimulus: NCH=2; reset, write Div1=4; En=1, Slt=0 for 10 cycles, then Slt=1 for 12 cycles.
   - Response: Count0=10 and Count1=3; Count0 holds at 10 throughout the Slt=1 phase.
2. Divisor and phase retention:
   - Stimulus: Div2=3; Slt=2, En=1 for 7 cycles; Slt=0 for 5 cycles; Slt=2 for 2 cycles.
   - Response: Count2=2 after the first phase, unchanged during the deselected phase, then Count2=3 (prescaler phase kept).
3. Wrap:
   - Stimulus: WIDTH=4, Sat=0, Div0=1, En=1, Slt=0 for 16 cycles.
   - Response: Count0 goes 0→15→0 and Tc[0] is high for exactly one cycle after the wrap edge.
4. Saturate:
   - Stimulus: WIDTH=4, Sat=1, 20 enabled cycles.
   - Response: Count0 sticks at 15; a single Tc[0] pulse when it reaches 15.
5. Priority:
   - Stimulus: Clr together with a tick on ch1; separately, Wr_en to ch1 together with a tick.
   - Response: Count1=0 after the Clr; no increment on the write cycle and the prescaler restarts.
6. Async reset and edge cases:
   - Stimulus: assert Reset_n=0 mid-cycle with counts nonzero; separately, Slt=NCH with En=1, and Div=0.
   - Response: all Count=0 and Div=DEF_DIV without a clock edge; no channel changes for Slt=NCH or Div=0.

Source files
------------

// File: rtl/multi_rate_counter_bank_pkg.sv
// Shared definitions for the multi-rate counter bank: count modes, default
// sizing and the flattened-bus slice helper.
package multi_rate_counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int unsigned MRC_WIDTH   = 64;
    localparam int unsigned MRC_NCH     = 4;
    localparam int unsigned MRC_SEL_W   = 2;
    localparam int unsigned MRC_DIV_W   = 8;
    localparam int unsigned MRC_DEF_DIV = 1;

    function automatic int unsigned ch_offset(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/multi_rate_counter_bank_if.sv
// Control/status bundle of the counter bank: select/enable/clear, divisor
// write port and the flattened counter and terminal-count outputs.
interface multi_rate_counter_bank_if
    import multi_rate_counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH = MRC_WIDTH,
    parameter int unsigned NCH   = MRC_NCH,
    parameter int unsigned SEL_W = MRC_SEL_W,
    parameter int unsigned DIV_W = MRC_DIV_W
) ();

    logic                   En;
    logic [SEL_W-1:0]       Slt;
    logic                   Clr;
    logic                   Sat;
    logic                   Wr_en;
    logic [SEL_W-1:0]       Wr_ch;
    logic [DIV_W-1:0]       Wr_div;
    logic [NCH*WIDTH-1:0]   Count;
    logic [NCH-1:0]         Tc;

    modport master (
        output En, Slt, Clr, Sat, Wr_en, Wr_ch, Wr_div,
        input  Count, Tc
    );

    modport slave (
        input  En, Slt, Clr, Sat, Wr_en, Wr_ch, Wr_div,
        output Count, Tc
    );

endinterface

// File: rtl/multi_rate_counter_bank_channel.sv
// One counter channel: divisor register, prescaler, wrap/saturate counter and
// registered terminal-count pulse.
module multi_rate_counter_bank_channel
    import multi_rate_counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = MRC_WIDTH,
    parameter int unsigned DIV_W   = MRC_DIV_W,
    parameter int unsigned DEF_DIV = MRC_DEF_DIV
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_sel,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_sat,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pre;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    mode_e            w_mode;
    logic             w_active;
    logic             w_tick;
    logic [WIDTH-1:0] w_next;
    logic             w_tc_next;

    assign w_mode   = mode_e'(i_sat);
    assign w_active = i_sel && i_en && (r_div != '0);
    assign w_tick   = w_active && (r_pre == r_div - DIV_W'(1));

    always_comb begin
        w_next    = r_count + WIDTH'(1);
        w_tc_next = 1'b0;
        if (r_count == CNT_MAX) begin
            if (w_mode == MODE_SAT) begin
                w_next = r_count;
            end else begin
                w_next    = '0;
                w_tc_next = 1'b1;
            end
        end else if ((w_mode == MODE_SAT) && (r_count == CNT_MAX - WIDTH'(1))) begin
            w_tc_next = 1'b1;
        end
    end

    // A divisor write is applied last so it overrides any prescaler update
    // and suppresses a coincident tick, while still combining with a clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div   <= DIV_W'(DEF_DIV);
            r_pre   <= '0;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_sel && i_clr) begin
                r_count <= '0;
                r_pre   <= '0;
            end else if (w_tick && !i_wr) begin
                r_count <= w_next;
                r_tc    <= w_tc_next;
                r_pre   <= '0;
            end else if (w_active) begin
                r_pre <= r_pre + DIV_W'(1);
            end
            if (i_wr) begin
                r_div <= i_wr_div;
                r_pre <= '0;
            end
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;

endmodule

// File: rtl/multi_rate_counter_bank.sv
// Bank of NCH independently divided counters; decodes the channel select and
// divisor-write index to one-hot and fans out to per-channel instances.
module multi_rate_counter_bank
    import multi_rate_counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = MRC_WIDTH,
    parameter int unsigned NCH     = MRC_NCH,
    parameter int unsigned SEL_W   = MRC_SEL_W,
    parameter int unsigned DIV_W   = MRC_DIV_W,
    parameter int unsigned DEF_DIV = MRC_DEF_DIV
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    multi_rate_counter_bank_if.slave   bus
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic w_sel;
        logic w_wr;

        // Out-of-range indices match no channel, so they are silently ignored.
        assign w_sel = (bus.Slt == SEL_W'(i));
        assign w_wr  = bus.Wr_en && (bus.Wr_ch == SEL_W'(i));

        multi_rate_counter_bank_channel #(
            .WIDTH   (WIDTH),
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .Clk      (Clk),
            .Reset_n  (Reset_n),
            .i_sel    (w_sel),
            .i_en     (bus.En),
            .i_clr    (bus.Clr),
            .i_sat    (bus.Sat),
            .i_wr     (w_wr),
            .i_wr_div (bus.Wr_div),
            .o_count  (bus.Count[ch_offset(i, WIDTH) +: WIDTH]),
            .o_tc     (bus.Tc[i])
        );
    end

endmodule

// File: tb/tb_multi_rate_counter_bank.sv
// Directed self-checking bench for the multi-rate counter bank (4-bit, 3 channels).
module tb_multi_rate_counter_bank;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam int DW = 8;

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 Clk = ~Clk;

    multi_rate_counter_bank_if #(.WIDTH(W), .NCH(N), .SEL_W(SW), .DIV_W(DW)) bus ();

    multi_rate_counter_bank #(
        .WIDTH   (W),
        .NCH     (N),
        .SEL_W   (SW),
        .DIV_W   (DW),
        .DEF_DIV (1)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    function automatic logic [W-1:0] cnt(input int ch);
        return bus.Count[ch*W +: W];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic run(input int slt, input int n);
        bus.Slt = SW'(slt);
        bus.En  = 1'b1;
        step(n);
        bus.En  = 1'b0;
    endtask

    task automatic write_div(input int ch, input int d);
        bus.Wr_en  = 1'b1;
        bus.Wr_ch  = SW'(ch);
        bus.Wr_div = DW'(d);
        step(1);
        bus.Wr_en  = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n    = 1'b0;
        bus.En     = 1'b0;
        bus.Slt    = '0;
        bus.Clr    = 1'b0;
        bus.Sat    = 1'b0;
        bus.Wr_en  = 1'b0;
        bus.Wr_ch  = '0;
        bus.Wr_div = '0;
        step(2);
        Reset_n    = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (bus.Count !== 12'h000) begin
            $display("FAIL reset_count got %h exp %h", bus.Count, 12'h000); n_fail++;
        end
        n_chk++;
        if (bus.Tc !== 3'b000) begin
            $display("FAIL reset_tc got %b exp %b", bus.Tc, 3'b000); n_fail++;
        end
    endtask

    task automatic test_legacy();
        do_reset();
        write_div(1, 4);
        run(0, 10);
        n_chk++;
        if (cnt(0) !== 4'd10) begin
            $display("FAIL legacy_cnt0 got %0d exp %0d", cnt(0), 10); n_fail++;
        end
        bus.Slt = 2'd1;
        bus.En  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1);
            n_chk++;
            if (cnt(0) !== 4'd10) begin
                $display("FAIL legacy_cnt0_hold cycle %0d got %0d exp %0d", k, cnt(0), 10); n_fail++;
            end
        end
        bus.En = 1'b0;
        n_chk++;
        if (cnt(1) !== 4'd3) begin
            $display("FAIL legacy_cnt1 got %0d exp %0d", cnt(1), 3); n_fail++;
        end
    endtask

    task automatic test_phase();
        do_reset();
        write_div(2, 3);
        run(2, 7);
        n_chk++;
        if (cnt(2) !== 4'd2) begin
            $display("FAIL phase_cnt2_first got %0d exp %0d", cnt(2), 2); n_fail++;
        end
        run(0, 5);
        n_chk++;
        if (bus.Count !== 12'h205) begin
            $display("FAIL phase_deselected got %h exp %h", bus.Count, 12'h205); n_fail++;
        end
        run(2, 1);
        n_chk++;
        if (cnt(2) !== 4'd2) begin
            $display("FAIL phase_cnt2_mid got %0d exp %0d", cnt(2), 2); n_fail++;
        end
        run(2, 1);
        n_chk++;
        if (cnt(2) !== 4'd3) begin
            $display("FAIL phase_cnt2_resume got %0d exp %0d", cnt(2), 3); n_fail++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        run(0, 15);
        n_chk++;
        if (cnt(0) !== 4'd15 || bus.Tc !== 3'b000) begin
            $display("FAIL wrap_at_max got cnt %0d tc %b exp cnt 15 tc 000", cnt(0), bus.Tc); n_fail++;
        end
        run(0, 1);
        n_chk++;
        if (cnt(0) !== 4'd0 || bus.Tc !== 3'b001) begin
            $display("FAIL wrap_edge got cnt %0d tc %b exp cnt 0 tc 001", cnt(0), bus.Tc); n_fail++;
        end
        run(0, 1);
        n_chk++;
        if (cnt(0) !== 4'd1 || bus.Tc !== 3'b000) begin
            $display("FAIL wrap_after got cnt %0d tc %b exp cnt 1 tc 000", cnt(0), bus.Tc); n_fail++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.Sat = 1'b1;
        run(0, 14);
        n_chk++;
        if (cnt(0) !== 4'd14 || bus.Tc !== 3'b000) begin
            $display("FAIL sat_pre got cnt %0d tc %b exp cnt 14 tc 000", cnt(0), bus.Tc); n_fail++;
        end
        run(0, 1);
        n_chk++;
        if (cnt(0) !== 4'd15 || bus.Tc !== 3'b001) begin
            $display("FAIL sat_reach got cnt %0d tc %b exp cnt 15 tc 001", cnt(0), bus.Tc); n_fail++;
        end
        for (int k = 0; k < 5; k++) begin
            run(0, 1);
            n_chk++;
            if (cnt(0) !== 4'd15 || bus.Tc !== 3'b000) begin
                $display("FAIL sat_hold cycle %0d got cnt %0d tc %b exp cnt 15 tc 000", k, cnt(0), bus.Tc); n_fail++;
            end
        end
        bus.Sat = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        write_div(1, 2);
        run(1, 5);
        n_chk++;
        if (cnt(1) !== 4'd2) begin
            $display("FAIL prio_setup got %0d exp %0d", cnt(1), 2); n_fail++;
        end
        bus.Slt = 2'd1;
        bus.En  = 1'b1;
        bus.Clr = 1'b1;
        step(1);
        bus.Clr = 1'b0;
        n_chk++;
        if (cnt(1) !== 4'd0) begin
            $display("FAIL prio_clr got %0d exp %0d", cnt(1), 0); n_fail++;
        end
        step(1);
        n_chk++;
        if (cnt(1) !== 4'd0) begin
            $display("FAIL prio_clr_pre_restart got %0d exp %0d", cnt(1), 0); n_fail++;
        end
        step(1);
        n_chk++;
        if (cnt(1) !== 4'd1) begin
            $display("FAIL prio_clr_tick got %0d exp %0d", cnt(1), 1); n_fail++;
        end
        step(1);
        bus.Wr_en  = 1'b1;
        bus.Wr_ch  = 2'd1;
        bus.Wr_div = 8'd2;
        step(1);
        bus.Wr_en  = 1'b0;
        n_chk++;
        if (cnt(1) !== 4'd1) begin
            $display("FAIL prio_wr_no_inc got %0d exp %0d", cnt(1), 1); n_fail++;
        end
        step(1);
        n_chk++;
        if (cnt(1) !== 4'd1) begin
            $display("FAIL prio_wr_pre_restart got %0d exp %0d", cnt(1), 1); n_fail++;
        end
        step(1);
        n_chk++;
        if (cnt(1) !== 4'd2) begin
            $display("FAIL prio_wr_tick got %0d exp %0d", cnt(1), 2); n_fail++;
        end
        bus.En = 1'b0;
    endtask

    task automatic test_edge_and_async();
        do_reset();
        run(0, 3);
        run(1, 2);
        bus.Slt    = 2'd3;
        bus.En     = 1'b1;
        bus.Clr    = 1'b1;
        bus.Wr_en  = 1'b1;
        bus.Wr_ch  = 2'd3;
        bus.Wr_div = 8'd0;
        step(2);
        bus.En     = 1'b0;
        bus.Clr    = 1'b0;
        bus.Wr_en  = 1'b0;
        n_chk++;
        if (bus.Count !== 12'h023) begin
            $display("FAIL edge_slt_out_of_range got %h exp %h", bus.Count, 12'h023); n_fail++;
        end
        run(0, 1);
        n_chk++;
        if (cnt(0) !== 4'd4) begin
            $display("FAIL edge_wr_ignored got %0d exp %0d", cnt(0), 4); n_fail++;
        end
        write_div(2, 0);
        run(2, 3);
        n_chk++;
        if (bus.Count !== 12'h024) begin
            $display("FAIL edge_div_zero got %h exp %h", bus.Count, 12'h024); n_fail++;
        end
        #2;
        Reset_n = 1'b0;
        #1;
        n_chk++;
        if (bus.Count !== 12'h000 || bus.Tc !== 3'b000) begin
            $display("FAIL async_reset got cnt %h tc %b exp cnt 000 tc 000", bus.Count, bus.Tc); n_fail++;
        end
        #1;
        Reset_n = 1'b1;
        run(2, 2);
        n_chk++;
        if (cnt(2) !== 4'd2) begin
            $display("FAIL async_reset_div got %0d exp %0d", cnt(2), 2); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_phase();
        test_wrap();
        test_saturate();
        test_priority();
        test_edge_and_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
